// File: rtl/fifo_async_upsize_pkg.sv
// fifo_async_upsize_pkg: shared constants, gray-code helpers and parameter checks for the up-sizing async FIFO.
package fifo_async_upsize_pkg;
  localparam logic RSTLEVEL = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s <<= 1) b ^= b >> s;
    return b;
  endfunction
  function automatic bit params_ok(input int dw_w, input int dw_r, input int size);
    int ratio, depth;
    ratio = dw_r / dw_w;
    depth = size / (dw_r / 8);
    return dw_w % 8 == 0 && dw_r == ratio * dw_w && ratio >= 2 && (ratio & (ratio - 1)) == 0 &&
           depth >= 4 && (depth & (depth - 1)) == 0 && depth * (dw_r / 8) == size;
  endfunction
endpackage

// File: rtl/fifo_async_upsize_if.sv
// fifo_async_upsize_if: write/read handshake bundle of the up-sizing async FIFO.
interface fifo_async_upsize_if #(
  parameter int DW_W = 32,
  parameter int DW_R = 64,
  parameter int SIZE = 64
);
  import fifo_async_upsize_pkg::*;
  localparam int RATIO = DW_R / DW_W;
  localparam int DEPTH = SIZE / (DW_R / 8);
  localparam int WCNT_W = clog2(DEPTH * RATIO) + 1;
  localparam int RCNT_W = clog2(DEPTH) + 1;
  logic w_req, full, r_req, empty;
  logic [DW_W-1:0] data_i;
  logic [DW_R-1:0] data_o;
  logic [WCNT_W-1:0] w_cnt;
  logic [RCNT_W-1:0] r_cnt;
  modport master (output w_req, data_i, r_req, input full, data_o, empty, w_cnt, r_cnt);
  modport slave (input w_req, data_i, r_req, output full, data_o, empty, w_cnt, r_cnt);
endinterface

// File: rtl/fifo_async_upsize_cdc.sv
// cdc_sync_2ff: two-flop bus synchronizer; only gray-coded or single-bit signals may cross through it.
module cdc_sync_2ff
  import fifo_async_upsize_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_m, r_q;
  always_ff @(posedge clk) begin
    if (rst == RSTLEVEL) begin
      r_m <= '0;
      r_q <= '0;
    end else begin
      r_m <= i_d;
      r_q <= r_m;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/fifo_async_upsize.sv
// fifo_async_upsize: dual-clock FIFO packing RATIO narrow writes into one wide first-word-fall-through read.
module fifo_async_upsize
  import fifo_async_upsize_pkg::*;
#(
  parameter int DW_W = 32,
  parameter int DW_R = 64,
  parameter int SIZE = 64
) (
  input logic clk_w,
  input logic clk_r,
  input logic rst,
  fifo_async_upsize_if.slave io_bus
);
  localparam int RATIO = DW_R / DW_W;
  localparam int DEPTH = SIZE / (DW_R / 8);
  localparam int AW = clog2(DEPTH);
  localparam int SW = clog2(RATIO);
  if (!params_ok(DW_W, DW_R, SIZE)) begin : g_bad_params
    $error("fifo_async_upsize: illegal DW_W/DW_R/SIZE combination");
  end
  logic [DW_R-1:0] r_mem [DEPTH];
  logic [RATIO-2:0][DW_W-1:0] r_lane;
  logic [SW-1:0] r_slot;
  logic [AW:0] r_wptr, r_wgray, r_rptr, r_rgray;
  logic r_full, r_empty;
  logic w_rst_r, w_wr, w_commit, w_rd;
  logic [AW:0] w_wnext, w_wgnext, w_rnext, w_rgnext, w_rsync, w_wsync;
  cdc_sync_2ff #(.W(1)) u_rst_sync (.clk(clk_r), .rst(~RSTLEVEL), .i_d(rst), .o_q(w_rst_r));
  cdc_sync_2ff #(.W(AW + 1)) u_wsync (.clk(clk_r), .rst(w_rst_r), .i_d(r_wgray), .o_q(w_wsync));
  cdc_sync_2ff #(.W(AW + 1)) u_rsync (.clk(clk_w), .rst(rst), .i_d(r_rgray), .o_q(w_rsync));
  // Full blocks packer lanes too, so a half-packed word never waits on a slot that cannot commit.
  assign w_wr = io_bus.w_req && !r_full;
  assign w_commit = w_wr && r_slot == SW'(RATIO - 1);
  assign w_wnext = r_wptr + (AW + 1)'(w_commit);
  assign w_wgnext = (AW + 1)'(bin2gray(32'(w_wnext)));
  always_ff @(posedge clk_w) begin
    if (rst == RSTLEVEL) begin
      r_slot <= '0;
      r_wptr <= '0;
      r_wgray <= '0;
      r_full <= 1'b0;
    end else begin
      r_slot <= r_slot + SW'(w_wr);
      r_wptr <= w_wnext;
      r_wgray <= w_wgnext;
      r_full <= w_wgnext == {~w_rsync[AW:AW-1], w_rsync[AW-2:0]};
    end
  end
  always_ff @(posedge clk_w) begin
    for (int k = 0; k < RATIO - 1; k++)
      if (w_wr && r_slot == SW'(k)) r_lane[k] <= io_bus.data_i;
    if (w_commit) r_mem[r_wptr[AW-1:0]] <= {io_bus.data_i, r_lane};
  end
  assign w_rd = io_bus.r_req && !r_empty;
  assign w_rnext = r_rptr + (AW + 1)'(w_rd);
  assign w_rgnext = (AW + 1)'(bin2gray(32'(w_rnext)));
  always_ff @(posedge clk_r) begin
    if (w_rst_r == RSTLEVEL) begin
      r_rptr <= '0;
      r_rgray <= '0;
      r_empty <= 1'b1;
    end else begin
      r_rptr <= w_rnext;
      r_rgray <= w_rgnext;
      r_empty <= w_rgnext == w_wsync;
    end
  end
  assign io_bus.full = r_full;
  assign io_bus.empty = r_empty;
  assign io_bus.data_o = r_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  // RATIO is a power of two, so appending the slot is the same as (diff*RATIO + slot).
  assign io_bus.w_cnt = {r_wptr - (AW + 1)'(gray2bin(32'(w_rsync))), r_slot};
  assign io_bus.r_cnt = (AW + 1)'(gray2bin(32'(w_wsync))) - r_rptr;
endmodule

// File: tb/tb_fifo_async_upsize.sv
// tb_fifo_async_upsize: directed and randomized-handshake checks of the 32->64 bit async FIFO.
module tb_fifo_async_upsize;
  logic clk_w = 0, clk_r = 0, rst = 1;
  int n_chk = 0, n_err = 0, wn = 0, rn = 0;
  bit ok, seen;
  fifo_async_upsize_if #(.DW_W(32), .DW_R(64), .SIZE(64)) bus ();
  fifo_async_upsize #(.DW_W(32), .DW_R(64), .SIZE(64)) dut (
    .clk_w(clk_w), .clk_r(clk_r), .rst(rst), .io_bus(bus.slave));
  always #5 clk_w = ~clk_w;
  always #13.5 clk_r = ~clk_r;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [31:0] d);
    @(negedge clk_w);
    bus.w_req = 1;
    bus.data_i = d;
    @(negedge clk_w);
    bus.w_req = 0;
  endtask
  task automatic rd();
    @(negedge clk_r);
    bus.r_req = 1;
    @(negedge clk_r);
    bus.r_req = 0;
  endtask
  task automatic wait_ne(input int n, output bit f);
    f = 0;
    for (int k = 0; k < n && !f; k++) begin
      @(negedge clk_r);
      f = !bus.empty;
    end
  endtask
  task automatic do_reset();
    @(negedge clk_w);
    rst = 1;
    repeat (4) @(posedge clk_r);
    @(negedge clk_w);
    rst = 0;
    repeat (5) @(negedge clk_r);
  endtask
  initial begin
    bus.w_req = 0;
    bus.r_req = 0;
    bus.data_i = 0;
    repeat (4) @(posedge clk_r);
    @(negedge clk_w);
    rst = 0;
    repeat (5) @(negedge clk_r);
    chk("rst_full", bus.full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_wcnt", bus.w_cnt, 0);
    chk("rst_rcnt", bus.r_cnt, 0);
    chk("rst_data", bus.data_o, 0);
    wr(32'h11111111);
    wr(32'h22222222);
    wait_ne(5, ok);
    chk("s2_visible", ok, 1);
    chk("s2_rcnt", bus.r_cnt, 1);
    chk("s2_data", bus.data_o, 64'h22222222_11111111);
    rd();
    chk("s2_empty", bus.empty, 1);
    chk("s2_data0", bus.data_o, 0);
    repeat (5) @(negedge clk_w);
    wr(32'hAAAA5555);
    chk("s3_wcnt", bus.w_cnt, 1);
    seen = 0;
    repeat (50) begin
      @(negedge clk_r);
      seen |= !bus.empty;
    end
    chk("s3_hold", seen, 0);
    wr(32'h0);
    wait_ne(5, ok);
    chk("s3_visible", ok, 1);
    chk("s3_data", bus.data_o, 64'h00000000_AAAA5555);
    rd();
    repeat (6) @(negedge clk_w);
    for (int k = 0; k < 16; k++) wr(32'h100 + k);
    chk("s4_full", bus.full, 1);
    chk("s4_wcnt", bus.w_cnt, 16);
    wr(32'hDEADBEEF);
    chk("s4_wcnt17", bus.w_cnt, 16);
    repeat (5) @(negedge clk_r);
    chk("s4_rcnt8", bus.r_cnt, 8);
    chk("s4_head", bus.data_o, {32'h101, 32'h100});
    rd();
    chk("s4_rcnt7", bus.r_cnt, 7);
    ok = 0;
    for (int k = 0; k < 5 && !ok; k++) begin
      @(negedge clk_w);
      ok = !bus.full;
    end
    chk("s4_unfull", ok, 1);
    chk("s4_wcnt14", bus.w_cnt, 14);
    for (int k = 1; k < 8; k++) begin
      chk("s4_drain", bus.data_o, {32'h101 + 32'(2 * k), 32'h100 + 32'(2 * k)});
      rd();
    end
    repeat (8) @(negedge clk_w);
    chk("s4_empty", bus.empty, 1);
    chk("s4_wcnt0", bus.w_cnt, 0);
    fork
      begin : writer
        bit pr, pf;
        pr = 0;
        pf = 0;
        for (int c = 0; c < 40000 && wn < 1000; c++) begin
          @(negedge clk_w);
          if (pr && !pf) wn++;
          bus.w_req = wn < 1000 ? 1'($urandom_range(0, 1)) : 1'b0;
          bus.data_i = 32'(wn);
          pr = bus.w_req;
          pf = bus.full;
        end
        bus.w_req = 0;
      end
      begin : reader
        bit pr, pe;
        logic [63:0] pd;
        pr = 0;
        pe = 1;
        pd = 0;
        for (int c = 0; c < 40000 && rn < 500; c++) begin
          @(negedge clk_r);
          if (pr && !pe) begin
            chk("s5_pair", pd, {32'(2 * rn + 1), 32'(2 * rn)});
            rn++;
          end
          bus.r_req = rn < 500 ? 1'($urandom_range(0, 1)) : 1'b0;
          pr = bus.r_req;
          pe = bus.empty;
          pd = bus.data_o;
        end
        bus.r_req = 0;
      end
    join
    chk("s5_words", wn, 1000);
    chk("s5_pairs", rn, 500);
    repeat (6) @(negedge clk_r);
    chk("s5_empty", bus.empty, 1);
    wr(32'h7);
    wr(32'h8);
    wr(32'h9);
    do_reset();
    chk("s6_empty", bus.empty, 1);
    chk("s6_wcnt", bus.w_cnt, 0);
    chk("s6_rcnt", bus.r_cnt, 0);
    chk("s6_data0", bus.data_o, 0);
    wr(32'h1);
    wr(32'h2);
    wait_ne(5, ok);
    chk("s6_visible", ok, 1);
    chk("s6_data", bus.data_o, 64'h00000002_00000001);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
